// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg
// Shared constants and types for the execute-stage branch resolver:
//   ADDR_WIDTH / DATA_WIDTH : PC and operand widths
//   br_funct3_e             : conditional-branch condition codes
//   br_state_e              : resolver FSM states
//   INSN_BYTES              : fall-through increment for a not-taken branch
// -----------------------------------------------------------------------------
package branch_resolve_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_funct3_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } br_state_e;

   localparam logic [ADDR_WIDTH-1:0] INSN_BYTES = ADDR_WIDTH'(4);

endpackage

// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
// Purely combinational evaluation of a conditional-branch condition.
// Ports:
//   funct3     in  3           condition code
//   op_a       in  DATA_WIDTH  rs1 operand
//   op_b       in  DATA_WIDTH  rs2 operand
//   taken      out 1           condition holds
//   valid_cond out 1           funct3 is a real branch code (010/011 are not)
// -----------------------------------------------------------------------------
module branch_cond_unit
   import branch_resolve_pkg::*;
(
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  taken,
   output logic                  valid_cond
);

   always_comb begin
      taken      = 1'b0;
      valid_cond = 1'b1;
      case (funct3)
         F3_BEQ:  taken = (op_a == op_b);
         F3_BNE:  taken = (op_a != op_b);
         F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
         F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
         F3_BLTU: taken = (op_a <  op_b);
         F3_BGEU: taken = (op_a >= op_b);
         default: valid_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Resolves conditional branches and JALR in EX against the fetch-time
// prediction, emits one-cycle registered predictor training strobes, and on a
// mispredict pulses flush and holds a fetch redirect until fetch accepts it.
// Saturating counters track resolved branches/JALRs and mispredicts.
// Ports:
//   cpu_clk, cpu_rstn                 clock, async active-low reset
//   ex_valid, ex_is_branch, ex_is_jalr, ex_funct3, ex_pc, ex_imm,
//   src_data1_ex, src_data2_ex        EX instruction and forwarded operands
//   ex_predict_taken/_target_pc       final fetch prediction
//   ex_predict1/3_taken, ex_is_loop   sub-predictor state carried from fetch
//   branch_ex, jalr_ex, branch_taken_ex, predict1/3_taken_ex, is_loop_ex,
//   branch_pc_ex, branch_target_pc    registered training outputs
//   redirect_valid/_pc, redirect_ready  fetch redirect handshake
//   flush                             one-cycle kill of younger instructions
//   ex_stall                          EX must hold while redirecting
//   branch_cnt, mispredict_cnt        saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rstn,
   input  logic                  ex_valid,
   input  logic                  ex_is_branch,
   input  logic                  ex_is_jalr,
   input  logic [2:0]            ex_funct3,
   input  logic [ADDR_WIDTH-1:0] ex_pc,
   input  logic [DATA_WIDTH-1:0] ex_imm,
   input  logic [DATA_WIDTH-1:0] src_data1_ex,
   input  logic [DATA_WIDTH-1:0] src_data2_ex,
   input  logic                  ex_predict_taken,
   input  logic [ADDR_WIDTH-1:0] ex_predict_target_pc,
   input  logic                  ex_predict1_taken,
   input  logic                  ex_predict3_taken,
   input  logic                  ex_is_loop,
   output logic                  branch_ex,
   output logic                  jalr_ex,
   output logic                  branch_taken_ex,
   output logic                  predict1_taken_ex,
   output logic                  predict3_taken_ex,
   output logic                  is_loop_ex,
   output logic [ADDR_WIDTH-1:0] branch_pc_ex,
   output logic [ADDR_WIDTH-1:0] branch_target_pc,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  redirect_ready,
   output logic                  flush,
   output logic                  ex_stall,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

   br_state_e             state_q, state_d;

   logic                  branch_ex_q,         branch_ex_d;
   logic                  jalr_ex_q,           jalr_ex_d;
   logic                  branch_taken_ex_q,   branch_taken_ex_d;
   logic                  predict1_taken_ex_q, predict1_taken_ex_d;
   logic                  predict3_taken_ex_q, predict3_taken_ex_d;
   logic                  is_loop_ex_q,        is_loop_ex_d;
   logic [ADDR_WIDTH-1:0] branch_pc_ex_q,      branch_pc_ex_d;
   logic [ADDR_WIDTH-1:0] branch_target_pc_q,  branch_target_pc_d;
   logic                  flush_q,             flush_d;
   logic [ADDR_WIDTH-1:0] redirect_pc_q,       redirect_pc_d;
   logic [CNT_WIDTH-1:0]  branch_cnt_q,        branch_cnt_d;
   logic [CNT_WIDTH-1:0]  mispredict_cnt_q,    mispredict_cnt_d;

   logic                  cond_taken;
   logic                  cond_valid;
   logic                  is_idle;
   logic                  resolve_br;
   logic                  resolve_jalr;
   logic                  resolve;
   logic [DATA_WIDTH-1:0] jalr_sum;
   logic [ADDR_WIDTH-1:0] jalr_target;
   logic [ADDR_WIDTH-1:0] br_target;
   logic                  actual_taken;
   logic [ADDR_WIDTH-1:0] actual_target;
   logic                  mispredict;
   logic [ADDR_WIDTH-1:0] fallthrough_pc;

   branch_cond_unit u_cond (
      .funct3     (ex_funct3),
      .op_a       (src_data1_ex),
      .op_b       (src_data2_ex),
      .taken      (cond_taken),
      .valid_cond (cond_valid)
   );

   // Resolution datapath. JALR takes priority if both type flags are set.
   always_comb begin
      is_idle        = (state_q == ST_IDLE);
      resolve_jalr   = ex_valid && is_idle && ex_is_jalr;
      resolve_br     = ex_valid && is_idle && !ex_is_jalr && ex_is_branch && cond_valid;
      resolve        = resolve_br || resolve_jalr;

      jalr_sum       = src_data1_ex + ex_imm;
      jalr_target    = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
      br_target      = ex_pc + ex_imm[ADDR_WIDTH-1:0];
      fallthrough_pc = ex_pc + INSN_BYTES;

      actual_taken   = ex_is_jalr ? 1'b1 : cond_taken;
      actual_target  = ex_is_jalr ? jalr_target : br_target;

      // A correctly predicted direction still mispredicts if both sides
      // agree on taken but disagree on where.
      mispredict     = resolve &&
                       ((actual_taken != ex_predict_taken) ||
                        (actual_taken && ex_predict_taken &&
                         (actual_target != ex_predict_target_pc)));
   end

   // FSM next state and held redirect PC.
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (mispredict) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = actual_taken ? actual_target : fallthrough_pc;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Training strobes: every value is forced to zero in cycles without a
   // resolution so the predictor never sees stale data.
   always_comb begin
      branch_ex_d         = resolve_br;
      jalr_ex_d           = resolve_jalr;
      branch_taken_ex_d   = resolve && actual_taken;
      predict1_taken_ex_d = resolve && ex_predict1_taken;
      predict3_taken_ex_d = resolve && ex_predict3_taken;
      is_loop_ex_d        = resolve && ex_is_loop;
      branch_pc_ex_d      = resolve ? ex_pc : '0;
      branch_target_pc_d  = resolve ? actual_target : '0;
      flush_d             = mispredict;
   end

   // Saturating counters: hold once all ones.
   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (resolve && (branch_cnt_q != '1))
         branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      if (mispredict && (mispredict_cnt_q != '1))
         mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q             <= ST_IDLE;
         branch_ex_q         <= 1'b0;
         jalr_ex_q           <= 1'b0;
         branch_taken_ex_q   <= 1'b0;
         predict1_taken_ex_q <= 1'b0;
         predict3_taken_ex_q <= 1'b0;
         is_loop_ex_q        <= 1'b0;
         branch_pc_ex_q      <= '0;
         branch_target_pc_q  <= '0;
         flush_q             <= 1'b0;
         redirect_pc_q       <= '0;
         branch_cnt_q        <= '0;
         mispredict_cnt_q    <= '0;
      end else begin
         state_q             <= state_d;
         branch_ex_q         <= branch_ex_d;
         jalr_ex_q           <= jalr_ex_d;
         branch_taken_ex_q   <= branch_taken_ex_d;
         predict1_taken_ex_q <= predict1_taken_ex_d;
         predict3_taken_ex_q <= predict3_taken_ex_d;
         is_loop_ex_q        <= is_loop_ex_d;
         branch_pc_ex_q      <= branch_pc_ex_d;
         branch_target_pc_q  <= branch_target_pc_d;
         flush_q             <= flush_d;
         redirect_pc_q       <= redirect_pc_d;
         branch_cnt_q        <= branch_cnt_d;
         mispredict_cnt_q    <= mispredict_cnt_d;
      end
   end

   always_comb begin
      branch_ex         = branch_ex_q;
      jalr_ex           = jalr_ex_q;
      branch_taken_ex   = branch_taken_ex_q;
      predict1_taken_ex = predict1_taken_ex_q;
      predict3_taken_ex = predict3_taken_ex_q;
      is_loop_ex        = is_loop_ex_q;
      branch_pc_ex      = branch_pc_ex_q;
      branch_target_pc  = branch_target_pc_q;
      flush             = flush_q;
      redirect_pc       = redirect_pc_q;
      redirect_valid    = (state_q == ST_REDIRECT);
      ex_stall          = (state_q == ST_REDIRECT);
      branch_cnt        = branch_cnt_q;
      mispredict_cnt    = mispredict_cnt_q;
   end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
   import branch_resolve_pkg::*;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn = 1'b1;
   logic        ex_valid, ex_is_branch, ex_is_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, src_data1_ex, src_data2_ex, ex_predict_target_pc;
   logic        ex_predict_taken, ex_predict1_taken, ex_predict3_taken, ex_is_loop;
   logic        redirect_ready;

   logic        branch_ex, jalr_ex, branch_taken_ex, predict1_taken_ex, predict3_taken_ex, is_loop_ex;
   logic [31:0] branch_pc_ex, branch_target_pc, redirect_pc;
   logic        redirect_valid, flush, ex_stall;
   logic [31:0] branch_cnt, mispredict_cnt;

   logic        s_branch_ex, s_jalr_ex, s_branch_taken_ex, s_predict1_taken_ex, s_predict3_taken_ex, s_is_loop_ex;
   logic [31:0] s_branch_pc_ex, s_branch_target_pc, s_redirect_pc;
   logic        s_redirect_valid, s_flush, s_ex_stall;
   logic [3:0]  s_branch_cnt, s_mispredict_cnt;

   always #5 cpu_clk = ~cpu_clk;

   branch_resolve #(.CNT_WIDTH(32)) u_dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .src_data1_ex(src_data1_ex), .src_data2_ex(src_data2_ex), .ex_predict_taken(ex_predict_taken),
      .ex_predict_target_pc(ex_predict_target_pc), .ex_predict1_taken(ex_predict1_taken),
      .ex_predict3_taken(ex_predict3_taken), .ex_is_loop(ex_is_loop), .branch_ex(branch_ex),
      .jalr_ex(jalr_ex), .branch_taken_ex(branch_taken_ex), .predict1_taken_ex(predict1_taken_ex),
      .predict3_taken_ex(predict3_taken_ex), .is_loop_ex(is_loop_ex), .branch_pc_ex(branch_pc_ex),
      .branch_target_pc(branch_target_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .flush(flush), .ex_stall(ex_stall), .branch_cnt(branch_cnt),
      .mispredict_cnt(mispredict_cnt)
   );

   branch_resolve #(.CNT_WIDTH(4)) u_dut4 (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .src_data1_ex(src_data1_ex), .src_data2_ex(src_data2_ex), .ex_predict_taken(ex_predict_taken),
      .ex_predict_target_pc(ex_predict_target_pc), .ex_predict1_taken(ex_predict1_taken),
      .ex_predict3_taken(ex_predict3_taken), .ex_is_loop(ex_is_loop), .branch_ex(s_branch_ex),
      .jalr_ex(s_jalr_ex), .branch_taken_ex(s_branch_taken_ex), .predict1_taken_ex(s_predict1_taken_ex),
      .predict3_taken_ex(s_predict3_taken_ex), .is_loop_ex(s_is_loop_ex), .branch_pc_ex(s_branch_pc_ex),
      .branch_target_pc(s_branch_target_pc), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
      .redirect_ready(redirect_ready), .flush(s_flush), .ex_stall(s_ex_stall), .branch_cnt(s_branch_cnt),
      .mispredict_cnt(s_mispredict_cnt)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state: whether a redirect is outstanding, its PC, and
   // unbounded event counts (saturation is applied when comparing).
   bit          m_redir;
   logic [31:0] m_rpc;
   longint      m_bcnt, m_mcnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] sat4(input longint n);
      return (n > 15) ? 4'hF : n[3:0];
   endfunction

   // Architectural meaning of the instruction currently in EX.
   function automatic void ref_eval(output bit res, output bit is_j, output bit taken,
                                    output logic [31:0] tgt, output bit mis);
      int sa, sb;
      bit real_branch;
      sa = int'(src_data1_ex);
      sb = int'(src_data2_ex);
      real_branch = ex_funct3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      is_j = ex_is_jalr;
      res  = ex_valid && !m_redir && (ex_is_jalr || (ex_is_branch && real_branch));
      if (ex_is_jalr) begin
         tgt   = (src_data1_ex + ex_imm) & 32'hFFFF_FFFE;
         taken = 1'b1;
      end else begin
         tgt = ex_pc + ex_imm;
         case (ex_funct3)
            3'd0:    taken = (src_data1_ex == src_data2_ex);
            3'd1:    taken = (src_data1_ex != src_data2_ex);
            3'd4:    taken = (sa < sb);
            3'd5:    taken = (sa >= sb);
            3'd6:    taken = (src_data1_ex < src_data2_ex);
            3'd7:    taken = (src_data1_ex >= src_data2_ex);
            default: taken = 1'b0;
         endcase
      end
      mis = res && ((taken != ex_predict_taken) || (taken && tgt != ex_predict_target_pc));
   endfunction

   task automatic drive(input bit v, input bit br, input bit jr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] s1,
                        input logic [31:0] s2, input bit pt, input logic [31:0] ptgt,
                        input bit p1, input bit p3, input bit lp);
      ex_valid = v; ex_is_branch = br; ex_is_jalr = jr; ex_funct3 = f3;
      ex_pc = pc; ex_imm = imm; src_data1_ex = s1; src_data2_ex = s2;
      ex_predict_taken = pt; ex_predict_target_pc = ptgt;
      ex_predict1_taken = p1; ex_predict3_taken = p3; ex_is_loop = lp;
   endtask

   task automatic idle();
      drive(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock: predict from the current inputs, clock, then compare.
   task automatic tick();
      bit res, is_j, tk, mis, hs, p1, p3, lp;
      logic [31:0] tgt, pc_s;
      ref_eval(res, is_j, tk, tgt, mis);
      hs = m_redir && redirect_ready;
      pc_s = ex_pc; p1 = ex_predict1_taken; p3 = ex_predict3_taken; lp = ex_is_loop;
      @(posedge cpu_clk);
      #1;
      if (res) begin
         m_bcnt++;
         if (mis) begin
            m_mcnt++;
            m_redir = 1'b1;
            m_rpc = tk ? tgt : pc_s + 32'd4;
         end
      end else if (hs) begin
         m_redir = 1'b0;
      end
      chk("branch_ex", branch_ex, res && !is_j);
      chk("jalr_ex", jalr_ex, res && is_j);
      chk("branch_taken_ex", branch_taken_ex, res && tk);
      chk("predict1_taken_ex", predict1_taken_ex, res && p1);
      chk("predict3_taken_ex", predict3_taken_ex, res && p3);
      chk("is_loop_ex", is_loop_ex, res && lp);
      chk("branch_pc_ex", branch_pc_ex, res ? pc_s : 32'd0);
      chk("branch_target_pc", branch_target_pc, res ? tgt : 32'd0);
      chk("flush", flush, mis);
      chk("redirect_valid", redirect_valid, m_redir);
      chk("ex_stall", ex_stall, m_redir);
      if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
      chk("branch_cnt", branch_cnt, 64'(m_bcnt));
      chk("mispredict_cnt", mispredict_cnt, 64'(m_mcnt));
      chk("branch_cnt_w4", s_branch_cnt, sat4(m_bcnt));
      chk("mispredict_cnt_w4", s_mispredict_cnt, sat4(m_mcnt));
   endtask

   task automatic do_reset();
      cpu_rstn = 1'b0;
      #1;
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_ex_stall", ex_stall, 0);
      chk("rst_flush", flush, 0);
      chk("rst_branch_ex", branch_ex, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_branch_cnt", branch_cnt, 0);
      chk("rst_mispredict_cnt", mispredict_cnt, 0);
      chk("rst_branch_cnt_w4", s_branch_cnt, 0);
      m_redir = 1'b0; m_rpc = '0; m_bcnt = 0; m_mcnt = 0;
      @(posedge cpu_clk);
      #1;
      cpu_rstn = 1'b1;
   endtask

   initial begin
      logic [2:0] f3_tab [8];
      logic [11:0] i12;
      logic [31:0] r_pc, r_imm, r_s1, r_s2, r_tgt;
      bit r_jr, r_br;

      f3_tab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
      redirect_ready = 1'b0;
      idle();
      #2;
      do_reset();

      // BEQ taken, predicted not-taken
      drive(1, 1, 0, 3'b000, 32'h100, 32'h40, 32'd5, 32'd5, 0, 32'h0, 1, 0, 1);
      tick();
      chk("beq_target", branch_target_pc, 32'h140);
      chk("beq_redirect_pc", redirect_pc, 32'h140);
      chk("beq_flush", flush, 1);
      chk("beq_mcnt", mispredict_cnt, 1);
      idle(); redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;

      // BLT signed taken, BLTU same operands not taken, both predicted right
      drive(1, 1, 0, 3'b100, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1, 1, 32'h220, 0, 1, 0);
      tick();
      chk("blt_taken", branch_taken_ex, 1);
      chk("blt_flush", flush, 0);
      drive(1, 1, 0, 3'b110, 32'h204, 32'h20, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 0, 0, 0);
      tick();
      chk("bltu_taken", branch_taken_ex, 0);
      chk("bltu_flush", flush, 0);
      chk("blt_bltu_bcnt", branch_cnt, 3);

      // JALR: bit0 of target cleared
      drive(1, 0, 1, 3'b000, 32'h300, 32'h10, 32'h2001, 32'h0, 1, 32'h2010, 0, 0, 0);
      tick();
      chk("jalr_ok_redirect", redirect_valid, 0);
      chk("jalr_ok_target", branch_target_pc, 32'h2010);
      drive(1, 0, 1, 3'b000, 32'h300, 32'h10, 32'h2001, 32'h0, 1, 32'h2000, 0, 0, 0);
      tick();
      chk("jalr_bad_redirect", redirect_valid, 1);
      chk("jalr_bad_redirect_pc", redirect_pc, 32'h2010);
      idle(); redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;

      // BNE not taken, predicted taken; redirect_ready low for 3 cycles
      drive(1, 1, 0, 3'b001, 32'h400, 32'h80, 32'd7, 32'd7, 1, 32'h480, 0, 0, 0);
      tick();
      chk("hold_flush_first", flush, 1);
      drive(1, 1, 0, 3'b000, 32'h500, 32'h8, 32'd1, 32'd1, 0, 32'h0, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_redirect_pc", redirect_pc, 32'h404);
         chk("hold_no_flush", flush, 0);
         chk("hold_no_strobe", branch_ex, 0);
      end
      redirect_ready = 1'b1;
      idle();
      tick();
      chk("hold_released", redirect_valid, 0);
      redirect_ready = 1'b0;

      // Reset in the second REDIRECT cycle
      drive(1, 1, 0, 3'b000, 32'h600, 32'h10, 32'd3, 32'd3, 0, 32'h0, 0, 0, 0);
      tick();
      idle();
      tick();
      chk("pre_reset_stall", ex_stall, 1);
      do_reset();
      drive(1, 1, 0, 3'b101, 32'h700, 32'h30, 32'd9, 32'd2, 1, 32'h730, 0, 0, 0);
      tick();
      chk("post_reset_branch_ex", branch_ex, 1);
      chk("post_reset_bcnt", branch_cnt, 1);

      // funct3 010 is not a branch
      drive(1, 1, 0, 3'b010, 32'h800, 32'h10, 32'd1, 32'd2, 1, 32'h810, 0, 0, 0);
      tick();
      chk("f3_010_strobe", branch_ex, 0);
      chk("f3_010_cnt", branch_cnt, 1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         r_jr  = ($urandom % 8) == 0;
         r_br  = !r_jr && (($urandom % 8) != 0);
         r_pc  = $urandom & 32'hFFFF_FFFC;
         i12   = 12'($urandom);
         r_imm = {{20{i12[11]}}, i12};
         r_s1  = (($urandom % 4) == 0) ? 32'($urandom % 8) : $urandom;
         r_s2  = (($urandom % 3) == 0) ? r_s1 : $urandom;
         r_tgt = r_jr ? ((r_s1 + r_imm) & 32'hFFFF_FFFE) : (r_pc + r_imm);
         if (($urandom % 4) == 0) r_tgt = $urandom;
         drive(($urandom % 8) != 0, r_br, r_jr, f3_tab[$urandom % 8], r_pc, r_imm, r_s1, r_s2,
               1'($urandom), r_tgt, 1'($urandom), 1'($urandom), 1'($urandom));
         redirect_ready = ($urandom % 3) == 0;
         tick();
      end
      redirect_ready = 1'b0;
      idle();

      // Saturation of the 4-bit counters with 20 mispredicting branches
      do_reset();
      redirect_ready = 1'b1;
      drive(1, 1, 0, 3'b000, 32'h900, 32'h40, 32'd4, 32'd4, 0, 32'h0, 0, 0, 0);
      for (int i = 0; i < 40; i++) tick();
      chk("sat_main_bcnt", branch_cnt, 20);
      chk("sat_main_mcnt", mispredict_cnt, 20);
      chk("sat_bcnt_w4", s_branch_cnt, 4'hF);
      chk("sat_mcnt_w4", s_mispredict_cnt, 4'hF);
      drive(1, 1, 0, 3'b010, 32'h900, 32'h40, 32'd4, 32'd4, 0, 32'h0, 0, 0, 0);
      tick();
      tick();
      chk("sat_f3_010_strobe", branch_ex, 0);
      chk("sat_f3_010_bcnt", branch_cnt, 20);
      chk("sat_f3_010_bcnt_w4", s_branch_cnt, 4'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
